// File: rtl/pwm_timebase.sv
// Prescaled PWM timebase with up, down, centre-aligned and one-shot counting.
// Period and prescale are shadowed and only take effect at cycle boundaries.
module pwm_timebase #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_reset,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count_val,
  output logic             dir,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_UPDN = 2'b10,
    M_ONE  = 2'b11
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pact_q, pact_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tick;
  logic             bnd;

  assign tick = en && (psc_q == pact_q);

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    psc_d  = psc_q;
    pact_d = pact_q;
    dir_d  = dir_q;
    busy_d = busy_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    bnd    = 1'b0;
    if (cnt_reset) begin
      mode_d = mode_e'(mode);
      per_d  = period;
      pact_d = prescale;
      psc_d  = '0;
      cnt_d  = (mode_e'(mode) == M_DOWN) ? period : '0;
      dir_d  = (mode_e'(mode) != M_DOWN);
      busy_d = 1'b0;
    end else if (en) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      case (mode_q)
        M_UP: begin
          if (tick) begin
            if (cnt_q == per_q) begin
              cnt_d = '0;
              ovf_d = 1'b1;
              bnd   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        M_DOWN: begin
          if (tick) begin
            if (cnt_q == '0) begin
              // reload uses the freshly shadowed period
              cnt_d = period;
              unf_d = 1'b1;
              bnd   = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        M_UPDN: begin
          if (tick) begin
            if (dir_q) begin
              if (cnt_q == per_q) begin
                ovf_d = 1'b1;
                if (per_q == '0) begin
                  cnt_d = '0;
                  bnd   = 1'b1;
                end else begin
                  cnt_d = per_q - 1'b1;
                  dir_d = 1'b0;
                end
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              if (cnt_q == '0) begin
                // a zero period reloaded here must not leave count above it
                cnt_d = (period == '0) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
                dir_d = 1'b1;
                unf_d = 1'b1;
                bnd   = 1'b1;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
          end
        end
        default: begin
          if (start && !busy_q) begin
            busy_d = 1'b1;
            psc_d  = '0;
            cnt_d  = '0;
          end else if (busy_q && tick) begin
            if (cnt_q == per_q) begin
              cnt_d  = '0;
              busy_d = 1'b0;
              ovf_d  = 1'b1;
              bnd    = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase
      if (bnd) begin
        per_d  = period;
        pact_d = prescale;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_UP;
      cnt_q  <= '0;
      per_q  <= '0;
      psc_q  <= '0;
      pact_q <= '0;
      dir_q  <= 1'b1;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      psc_q  <= psc_d;
      pact_q <= pact_d;
      dir_q  <= dir_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign count_val = cnt_q;
  assign dir       = dir_q;
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;
  assign busy      = busy_q;

endmodule
